// File: rtl/text_render_seq.sv
// Character-cell text renderer: 80x30 cells of 8x16 glyphs on 640x480.
// Five-stage fixed-latency pipeline: text fetch, font fetch, pixel select.
module text_render_seq #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int TBUF_AW      = 12,
  parameter int FONT_AW      = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [9:0]         hpos_i,
  input  logic [9:0]         vpos_i,
  input  logic               active_i,
  input  logic               frame_i,
  output logic [TBUF_AW-1:0] tbuf_addr_o,
  input  logic [7:0]         tbuf_data_i,
  output logic [FONT_AW-1:0] font_addr_o,
  input  logic [7:0]         font_data_i,
  input  logic               cursor_en_i,
  input  logic [6:0]         cursor_col_i,
  input  logic [4:0]         cursor_row_i,
  output logic               pixel_o,
  output logic               active_o
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [6:0]         col;
  logic [5:0]         row;
  logic [TBUF_AW-1:0] tbuf_addr_d, tbuf_addr_q;
  logic [FONT_AW-1:0] font_addr_d, font_addr_q;
  logic               cur_hit_d;
  logic [3:0]         act_q;
  logic [3:0]         cur_q;
  logic [3:0][2:0]    xbit_q;
  logic [1:0][3:0]    grow_q;
  logic [1:0]         inv_q;
  logic [BW-1:0]      cnt_d, cnt_q;
  logic               blink_d, blink_q;
  logic               pixel_d, pixel_q;
  logic               act_out_q;

  assign col = hpos_i[9:3];
  assign row = vpos_i[9:4];

  always_comb begin
    tbuf_addr_d = tbuf_addr_q;
    if (active_i)
      tbuf_addr_d = TBUF_AW'(row) * TBUF_AW'(COLS)
                  + TBUF_AW'(col);
  end

  assign cur_hit_d = cursor_en_i
                   & (col == cursor_col_i)
                   & (row == {1'b0, cursor_row_i})
                   & (vpos_i[3:0] >= 4'd14);

  // Bit 7 of the character is the inverse attribute, never a glyph bit.
  always_comb begin
    font_addr_d = font_addr_q;
    if (act_q[1])
      font_addr_d = FONT_AW'({tbuf_data_i[6:0], grow_q[1]});
  end

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (frame_i) begin
      if (cnt_q == BW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pixel_d = act_q[3]
                 & (font_data_i[xbit_q[3]]
                    ^ inv_q[1]
                    ^ (cur_q[3] & blink_q));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tbuf_addr_q <= '0;
      font_addr_q <= '0;
      act_q       <= '0;
      cur_q       <= '0;
      xbit_q      <= '0;
      grow_q      <= '0;
      inv_q       <= '0;
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      pixel_q     <= 1'b0;
      act_out_q   <= 1'b0;
    end else begin
      tbuf_addr_q <= tbuf_addr_d;
      font_addr_q <= font_addr_d;
      act_q       <= {act_q[2:0], active_i};
      cur_q       <= {cur_q[2:0], cur_hit_d};
      xbit_q      <= {xbit_q[2:0], hpos_i[2:0]};
      grow_q      <= {grow_q[0], vpos_i[3:0]};
      inv_q       <= {inv_q[0], tbuf_data_i[7] & act_q[1]};
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      pixel_q     <= pixel_d;
      act_out_q   <= act_q[3];
    end
  end

  assign tbuf_addr_o = tbuf_addr_q;
  assign font_addr_o = font_addr_q;
  assign pixel_o     = pixel_q;
  assign active_o    = act_out_q;

endmodule

// File: tb/tb_text_render_seq.sv
// Scoreboard bench for text_render_seq with behavioural text/font memories.
// Directed vectors push expected outputs; a negedge monitor compares them.
module tb_text_render_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        active = 1'b0;
  logic        frame = 1'b0;
  logic [11:0] tbuf_addr;
  logic [7:0]  tbuf_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        cur_en = 1'b0;
  logic [6:0]  cur_col = 7'd5;
  logic [4:0]  cur_row = 5'd2;
  logic        pixel;
  logic        act_o;

  text_render_seq dut (
    .clk_i(clk), .rstn_i(rstn),
    .hpos_i(hpos), .vpos_i(vpos),
    .active_i(active), .frame_i(frame),
    .tbuf_addr_o(tbuf_addr), .tbuf_data_i(tbuf_data),
    .font_addr_o(font_addr), .font_data_i(font_data),
    .cursor_en_i(cur_en), .cursor_col_i(cur_col),
    .cursor_row_i(cur_row),
    .pixel_o(pixel), .active_o(act_o)
  );

  always #20 clk = ~clk;

  logic [7:0] tmem [4096];
  logic [7:0] fmem [2048];

  always @(posedge clk) begin
    tbuf_data <= tmem[tbuf_addr];
    font_data <= fmem[font_addr];
  end

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t pq[$];
  exp_t tq[$];
  exp_t fq[$];

  int cyc = 0;
  int stamp = 0;
  int passed = 0;
  int total = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm,
                       input logic [11:0] act,
                       input logic [11:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  nm, cyc, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      while (pq.size() > 0 && pq[0].due == cyc) begin
        e = pq.pop_front();
        check("pix", {10'd0, act_o, pixel}, e.val);
      end
      while (tq.size() > 0 && tq[0].due == cyc) begin
        e = tq.pop_front();
        check("tbuf_addr", tbuf_addr, e.val);
      end
      while (fq.size() > 0 && fq[0].due == cyc) begin
        e = fq.pop_front();
        check("font_addr", {1'b0, font_addr}, e.val);
      end
    end
  end

  task automatic issue(input int h, input int v,
                       input logic a, input logic f,
                       input logic ea, input logic ep);
    @(posedge clk); #1;
    hpos   = 10'(h);
    vpos   = 10'(v);
    active = a;
    frame  = f;
    stamp  = cyc;
    pq.push_back('{stamp + 5, {10'd0, ea, ep}});
  endtask

  task automatic exp_tbuf(input int val);
    tq.push_back('{stamp + 1, 12'(val)});
  endtask

  task automatic exp_font(input int val);
    fq.push_back('{stamp + 3, 12'(val)});
  endtask

  // Eight pixels of one glyph row, pattern bit 7 = hpos offset 0.
  task automatic row8(input int h0, input int v,
                      input logic [7:0] pat);
    for (int i = 0; i < 8; i++)
      issue(h0 + i, v, 1'b1, 1'b0, 1'b1, pat[7 - i]);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      issue(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tmem[i] = 8'h20;
    for (int i = 0; i < 2048; i++) fmem[i] = 8'h00;
    for (int r = 0; r < 16; r++) fmem[12'h410 + r] = 8'h81;
    fmem[11'h7FF] = 8'h80;
    tmem[0]    = 8'h41;
    tmem[1]    = 8'hC1;
    tmem[165]  = 8'h41;
    tmem[2399] = 8'h7F;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pix", {10'd0, act_o, pixel}, 12'd0);
    check("rst_tbuf", tbuf_addr, 12'd0);
    check("rst_font", {1'b0, font_addr}, 12'd0);
    rstn = 1'b1;

    // Cell 0, code 0x41, glyph row 0.
    issue(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_tbuf(0);
    exp_font(12'h410);
    for (int i = 1; i < 8; i++)
      issue(i, 0, 1'b1, 1'b0, 1'b1, i == 7);

    // Cell 1, code 0xC1: same glyph, inverted.
    issue(8, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_tbuf(1);
    exp_font(12'h410);
    for (int i = 1; i < 8; i++)
      issue(8 + i, 0, 1'b1, 1'b0, 1'b1, i != 7);

    // Ten inactive slots: addresses hold, outputs zero.
    for (int i = 0; i < 10; i++) begin
      issue(16 + i, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_tbuf(1);
      exp_font(12'h410);
    end

    // Bottom-right corner pixel.
    issue(639, 479, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_tbuf(2399);
    exp_font(12'h7FF);

    // Cursor at col 5 row 2, shown after 30 frames.
    cur_en = 1'b1;
    strobes(30);
    row8(40, 46, 8'b0111_1110);
    row8(40, 47, 8'b0111_1110);
    row8(40, 45, 8'b1000_0001);
    row8(48, 46, 8'b0000_0000);
    strobes(30);
    row8(40, 46, 8'b1000_0001);
    strobes(30);
    cur_en = 1'b0;
    row8(40, 47, 8'b1000_0001);

    // Mid-line reset with pixels in flight.
    issue(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(8, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(9, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(10, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    active = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("arst_pix", {10'd0, act_o, pixel}, 12'd0);
    check("arst_tbuf", tbuf_addr, 12'd0);
    check("arst_font", {1'b0, font_addr}, 12'd0);
    pq.delete();
    tq.delete();
    fq.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(7, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_tbuf(0);
    exp_font(12'h410);
    issue(8, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    if (pq.size() + tq.size() + fq.size() != 0) begin
      total++;
      $display("FAIL drain left=%0d want=0",
               pq.size() + tq.size() + fq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
